seq_pattern_detector: RTL and testbench
=======================================

// Module: seq_pattern_detector
// PURPOSE
//  Parametrised serial bit-pattern detector; successor to the fixed 4-bit "1001" code checker.
//  Samples one serial bit per qualified clock and compares the last PAT_W bits with a programmable pattern.
//  Supports overlapping/non-overlapping search, pulse/sticky output and a saturating match counter.
//  Sits between a serial input front end and status/control logic in the lab SoC.
// PARAMETERS
//  PAT_W     4        pattern length in bits (>=2)
//  PAT_RST   4'b1001  pattern loaded at reset, PAT_W bits, MSB = oldest bit
//  CNT_W     8        match counter width (>=1)
// PORTS
//  clk          in   1      system clock, all state on posedge
//  rst_n        in   1      asynchronous active-low reset
//  x_valid      in   1      x is sampled this cycle
//  x            in   1      serial data bit
//  mode_overlap in   1      1: overlapping search; 0: history flushed after each match
//  mode_sticky  in   1      1: out held until clear; 0: out is a one-cycle pulse
//  clear        in   1      sync clear of history, out and match_cnt
//  pat_load     in   1      load pat_in as the new pattern
//  pat_in       in   PAT_W  new pattern value, MSB = oldest bit
//  out          out  1      match indication (registered)
//  match_cnt    out  CNT_W  number of matches, saturating
//  primed       out  1      1 when >=PAT_W-1 valid bits are held, so the next bit can complete a match
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - shreg=0, fill=0, pattern=PAT_RST, out=0, match_cnt=0, primed=0.
//  Sampling (x_valid=1, no clear, no pat_load):
//   - shreg <= {shreg[PAT_W-2:0], x}.
//   - fill increments and saturates at PAT_W-1.
//  Match condition, evaluated on the sampling edge:
//   - fill==PAT_W-1 and {shreg[PAT_W-2:0], x}==pattern.
//  Latency: out is high in the cycle after the edge that captured the last pattern bit.
//  Pulse mode:
//   - out=1 for exactly one cycle per match.
//   - Back-to-back matches give consecutive high cycles.
//  Sticky mode:
//   - out set on a match, held until clear or reset.
//   - Switching mode_sticky 1->0 while out=1 drops out on the next edge.
//  Overlap mode: fill is unchanged on a match; e.g. pattern 1001 on 1001001 gives 2 matches.
//  Non-overlap mode:
//   - On a match, fill <= 0 and shreg <= 0.
//   - Pattern 1001 on 1001001 gives 1 match.
//  match_cnt increments by 1 per match and holds at 2^CNT_W-1; it does not wrap.
//  x_valid=0: no state change; pulse-mode out returns to 0.
//  clear (sync) has top priority:
//   - shreg, fill, out, match_cnt <= 0.
//   - A same-cycle match is discarded and not counted.
//  pat_load (sync, second priority):
//   - pattern <= pat_in; shreg, fill <= 0.
//   - A same-cycle x bit is discarded; out and match_cnt are kept, pulse out drops to 0.
//  primed = (fill==PAT_W-1), a registered-state decode.
//  FSM view: FILLING (fill<PAT_W-1) -> PRIMED -> PRIMED (overlap) or FILLING (non-overlap, on a match).
// STRUCTURE
//  Package seq_det_pkg holds:
//   - default PAT_W, PAT_RST and CNT_W constants;
//   - fill-width function clog2(PAT_W).
//  Sub-module sat_counter #(W) (clk, rst_n, clr, inc, q):
//   - used for match_cnt;
//   - also reusable for fill, with saturation at a parameter value.
//  The top contains the shift register, pattern register, compare and output register.
// TESTING
//  T1 Reset default, overlap, pulse; stream 1001001 -> out pulses on bits 4 and 7, match_cnt=2.
//  T2 Non-overlap, same stream -> one pulse after bit 4; bit 7 gives no match; match_cnt=1.
//  T3 Sticky; stream 1001 then 0000 -> out=1 from bit 4 until clear; clear -> out=0, cnt=0.
//  T4 pat_load 0110 mid-stream, then 0110 -> primed=0 after load, single match, old history ignored.
//  T5 CNT_W=2, 5 overlapping matches of 11 (PAT_W=2, PAT_RST=2'b11) on 111111 -> cnt saturates at 3.
//  T6 Async rst_n pulse mid-pattern (after 100) then 1 -> no match, all outputs 0; clear+match same edge -> cnt stays 0.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants, state encoding and width helper for the serial pattern detector.
package seq_det_pkg;

  localparam int         DEF_PAT_W   = 4;
  localparam logic [3:0] DEF_PAT_RST = 4'b1001;
  localparam int         DEF_CNT_W   = 8;

  typedef enum logic {
    FILLING = 1'b0,
    PRIMED  = 1'b1
  } det_state_e;

  // Bits needed to hold a fill count of 0..n-1, never less than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/seq_pattern_detector_if.sv
// Serial data, mode/control and status bundle between the front end and the detector.
interface seq_pattern_detector_if
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W
);

  logic             x_valid;
  logic             x;
  logic             mode_overlap;
  logic             mode_sticky;
  logic             clear;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic             out;
  logic [CNT_W-1:0] match_cnt;
  logic             primed;

  modport master (
    output x_valid, x, mode_overlap, mode_sticky, clear, pat_load, pat_in,
    input  out, match_cnt, primed
  );

  modport slave (
    input  x_valid, x, mode_overlap, mode_sticky, clear, pat_load, pat_in,
    output out, match_cnt, primed
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that holds at MAX instead of wrapping.
module sat_counter #(
  parameter int         W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != MAX)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: history shift register, programmable pattern, compare,
// registered match output and saturating match counter.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(DEF_PAT_RST),
  parameter int               CNT_W   = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_pattern_detector_if.slave bus
);

  localparam int                FILL_W   = clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
  localparam logic [FILL_W-1:0] FILL_PRE = FILL_W'(PAT_W - 2);

  det_state_e       state, state_next;
  logic [PAT_W-2:0] shreg, shreg_next;
  logic [PAT_W-1:0] pattern, pattern_next;
  logic [PAT_W-1:0] window;
  logic             out_q, out_next;
  logic [FILL_W-1:0] fill;
  logic             sample, match, fill_clr;

  // clear and pat_load both swallow the bit offered on the same edge.
  assign sample   = bus.x_valid & ~bus.clear & ~bus.pat_load;
  assign window   = {shreg, bus.x};
  assign match    = sample && (state == PRIMED) && (window == pattern);
  assign fill_clr = bus.clear | bus.pat_load | (match & ~bus.mode_overlap);

  sat_counter #(.W(FILL_W), .MAX(FILL_MAX)) fill_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (fill_clr),
    .inc   (sample),
    .q     (fill)
  );

  sat_counter #(.W(CNT_W)) match_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.clear),
    .inc   (match),
    .q     (bus.match_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FILLING;
      shreg   <= '0;
      pattern <= PAT_RST;
      out_q   <= 1'b0;
    end else begin
      state   <= state_next;
      shreg   <= shreg_next;
      pattern <= pattern_next;
      out_q   <= out_next;
    end
  end

  // PRIMED tracks fill==PAT_W-1; a non-overlapping match flushes back to FILLING.
  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    pattern_next = pattern;
    out_next     = bus.mode_sticky ? out_q : 1'b0;
    if (bus.clear) begin
      state_next = FILLING;
      shreg_next = '0;
      out_next   = 1'b0;
    end else if (bus.pat_load) begin
      state_next   = FILLING;
      shreg_next   = '0;
      pattern_next = bus.pat_in;
    end else if (bus.x_valid) begin
      if (match) begin
        out_next = 1'b1;
      end
      if (match && !bus.mode_overlap) begin
        state_next = FILLING;
        shreg_next = '0;
      end else begin
        shreg_next = window[PAT_W-2:0];
        if ((state == PRIMED) || (fill == FILL_PRE)) begin
          state_next = PRIMED;
        end
      end
    end
  end

  assign bus.out    = out_q;
  assign bus.primed = (state == PRIMED);

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed-vector bench for seq_pattern_detector: default 4-bit instance plus a 2-bit/2-bit-counter instance.
module tb_seq_pattern_detector;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  seq_pattern_detector_if #(.PAT_W(4), .CNT_W(8)) bus  ();
  seq_pattern_detector_if #(.PAT_W(2), .CNT_W(2)) bus2 ();

  seq_pattern_detector #(.PAT_W(4), .PAT_RST(4'b1001), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  seq_pattern_detector #(.PAT_W(2), .PAT_RST(2'b11), .CNT_W(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle on the falling edge, return just after the following rising edge.
  task automatic applyStimulus(input logic v, input logic b, input logic c, input logic l, input logic [3:0] p);
    @(negedge clk);
    bus.x_valid  = v;
    bus.x        = b;
    bus.clear    = c;
    bus.pat_load = l;
    bus.pat_in   = p;
    @(posedge clk);
    #1;
  endtask

  task automatic sendBits(input string tag, input int n, input logic [7:0] bits, input logic [7:0] exp);
    for (int i = n - 1; i >= 0; i--) begin
      applyStimulus(1'b1, bits[i], 1'b0, 1'b0, 4'b0000);
      checkOutput($sformatf("%s_out%0d", tag, n - i), 32'(bus.out), 32'(exp[i]));
    end
  endtask

  task automatic applyStimulus2(input logic b);
    @(negedge clk);
    bus2.x_valid = 1'b1;
    bus2.x       = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.x_valid = 1'b0; bus.x = 1'b0; bus.clear = 1'b0; bus.pat_load = 1'b0;
    bus.pat_in = 4'b0000; bus.mode_overlap = 1'b1; bus.mode_sticky = 1'b0;
    bus2.x_valid = 1'b0; bus2.x = 1'b0; bus2.clear = 1'b0; bus2.pat_load = 1'b0;
    bus2.pat_in = 2'b00; bus2.mode_overlap = 1'b1; bus2.mode_sticky = 1'b0;

    #3;
    checkOutput("rst_out",     32'(bus.out),        32'd0);
    checkOutput("rst_cnt",     32'(bus.match_cnt),  32'd0);
    checkOutput("rst_primed",  32'(bus.primed),     32'd0);
    checkOutput("rst2_cnt",    32'(bus2.match_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // T1: overlapping pulse mode, 1001001 -> pulses after bits 4 and 7
    sendBits("t1", 7, 8'b0100_1001, 8'b0000_1001);
    checkOutput("t1_cnt",    32'(bus.match_cnt), 32'd2);
    checkOutput("t1_primed", 32'(bus.primed),    32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
    checkOutput("t1_clr_cnt",    32'(bus.match_cnt), 32'd0);
    checkOutput("t1_clr_primed", 32'(bus.primed),    32'd0);

    // T2: non-overlapping, same stream -> single match, history flushed
    bus.mode_overlap = 1'b0;
    sendBits("t2a", 4, 8'b0000_1001, 8'b0000_0001);
    checkOutput("t2_primed_flush", 32'(bus.primed), 32'd0);
    sendBits("t2b", 3, 8'b0000_0001, 8'b0000_0000);
    checkOutput("t2_cnt",    32'(bus.match_cnt), 32'd1);
    checkOutput("t2_primed", 32'(bus.primed),    32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);

    // T3: sticky out held, dropped by leaving sticky mode, counter cleared
    bus.mode_overlap = 1'b1;
    bus.mode_sticky  = 1'b1;
    sendBits("t3", 8, 8'b1001_0000, 8'b0001_1111);
    checkOutput("t3_cnt", 32'(bus.match_cnt), 32'd1);
    bus.mode_sticky = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    checkOutput("t3_unstick", 32'(bus.out), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
    checkOutput("t3_clr_cnt", 32'(bus.match_cnt), 32'd0);

    // T4: reload pattern mid-stream; offered bit discarded, count kept
    sendBits("t4a", 6, 8'b0010_0110, 8'b0000_0100);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'b0110);
    checkOutput("t4_load_primed", 32'(bus.primed),    32'd0);
    checkOutput("t4_load_cnt",    32'(bus.match_cnt), 32'd1);
    checkOutput("t4_load_out",    32'(bus.out),       32'd0);
    sendBits("t4b", 2, 8'b0000_0001, 8'b0000_0000);
    checkOutput("t4_primed2", 32'(bus.primed), 32'd0);
    sendBits("t4c", 2, 8'b0000_0010, 8'b0000_0001);
    checkOutput("t4_cnt", 32'(bus.match_cnt), 32'd2);

    // T5: 2-bit pattern 11, 2-bit counter saturates at 3
    for (int i = 1; i <= 6; i++) begin
      applyStimulus2(1'b1);
      checkOutput($sformatf("t5_out%0d", i), 32'(bus2.out),       32'((i >= 2) ? 1 : 0));
      checkOutput($sformatf("t5_cnt%0d", i), 32'(bus2.match_cnt), 32'((i - 1 > 3) ? 3 : i - 1));
    end
    @(negedge clk);
    bus2.x_valid = 1'b0;

    // T6: async reset mid-pattern restores 1001; clear beats a same-edge match
    sendBits("t6a", 3, 8'b0000_0100, 8'b0000_0000);
    @(negedge clk);
    bus.x_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_async_primed", 32'(bus.primed),    32'd0);
    checkOutput("t6_async_cnt",    32'(bus.match_cnt), 32'd0);
    #1 rst_n = 1'b1;
    sendBits("t6b", 1, 8'b0000_0001, 8'b0000_0000);
    checkOutput("t6_cnt",    32'(bus.match_cnt), 32'd0);
    checkOutput("t6_primed", 32'(bus.primed),    32'd0);
    sendBits("t6c", 3, 8'b0000_0100, 8'b0000_0000);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
    checkOutput("t6_clrmatch_out", 32'(bus.out),       32'd0);
    checkOutput("t6_clrmatch_cnt", 32'(bus.match_cnt), 32'd0);
    sendBits("t6d", 4, 8'b0000_1001, 8'b0000_0001);
    checkOutput("t6_pat_restored_cnt", 32'(bus.match_cnt), 32'd1);

    @(negedge clk);
    bus.x_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
